// File: rtl/fetch_unit.sv
// fetch_unit: IF stage owning the PC, driving instruction memory and filling the IF/ID register
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MEM_BYTES  = 1024,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  output logic        imem_rd_en,
  input  logic [31:0] imem_rd,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        fetch_err
);
  typedef enum logic {RUN, HALT} state_t;
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
  state_t state;
  logic [31:0] pc;
  logic run, oor, hit_halt, live, bub, cap, to_halt, pc_inc;
  assign imem_addr  = pc;
  assign imem_rd_en = state == RUN;
  assign halted     = state == HALT;
  assign run      = state == RUN;
  assign oor      = pc > LAST_PC;
  assign hit_halt = imem_rd == HALT_INSTR;
  assign live     = run & ~redirect & ~flush;
  assign cap      = live & ~stall & ~oor & ~hit_halt;
  assign to_halt  = live & (oor | (~stall & hit_halt));
  assign bub      = redirect | (~run & ~stall) | (run & flush) | to_halt;
  assign pc_inc   = cap | (run & ~redirect & flush & ~stall);
  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= RESET_PC;
      state      <= RUN;
      ifid_instr <= NOP_INSTR;
      ifid_pc    <= '0;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
      fetch_err  <= 1'b0;
    end else begin
      if (redirect) pc <= {redirect_pc[31:2], 2'b00};
      else if (pc_inc) pc <= pc + 32'd4;
      if (redirect) state <= RUN;
      else if (to_halt) state <= HALT;
      if (bub) begin
        ifid_instr <= NOP_INSTR;
        ifid_pc    <= '0;
        ifid_pc4   <= '0;
        ifid_valid <= 1'b0;
      end else if (cap) begin
        ifid_instr <= imem_rd;
        ifid_pc    <= pc;
        ifid_pc4   <= pc + 32'd4;
        ifid_valid <= 1'b1;
      end
      if (live & oor) fetch_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic checked against a behavioural model
module tb_fetch_unit;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] I0 = 32'h00A0_0013, I1 = 32'h0010_8093, I2 = 32'h0021_0113;
  localparam logic [31:0] W40 = 32'h4040_4040, WEND = 32'hCAFE_F00D;
  logic clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = '0, imem_addr, imem_rd, ifid_instr, ifid_pc, ifid_pc4;
  logic imem_rd_en, ifid_valid, halted, fetch_err;
  logic [31:0] mem [256];
  int checks = 0, errors = 0;
  logic m_init = 1'b0, m_halt, m_err, m_v;
  logic [31:0] m_pc, m_ins, m_ipc, m_ipc4;

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rd_en(imem_rd_en),
    .imem_rd(imem_rd), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_valid(ifid_valid), .halted(halted), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;
  assign imem_rd = (imem_addr <= 32'd1020) ? mem[imem_addr[9:2]] : 32'hDEAD_BEEF;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic set_bubble();
    m_ins = '0; m_ipc = '0; m_ipc4 = '0; m_v = 1'b0;
  endtask

  always @(posedge clk) begin
    logic [31:0] w;
    w = (m_pc <= 32'd1020) ? mem[m_pc[9:2]] : 32'hDEAD_BEEF;
    if (rst) begin
      m_init = 1'b1; m_pc = '0; m_halt = 1'b0; m_err = 1'b0; set_bubble();
    end else if (m_init) begin
      if (redirect) begin
        m_pc = redirect_pc & ~32'd3; m_halt = 1'b0; set_bubble();
      end else if (m_halt) begin
        if (!stall) set_bubble();
      end else if (flush) begin
        set_bubble();
        if (!stall) m_pc += 4;
      end else if (m_pc > 32'd1020) begin
        set_bubble(); m_err = 1'b1; m_halt = 1'b1;
      end else if (!stall) begin
        if (w == HALT) begin
          set_bubble(); m_halt = 1'b1;
        end else begin
          m_ins = w; m_ipc = m_pc; m_ipc4 = m_pc + 4; m_v = 1'b1; m_pc += 4;
        end
      end
    end
  end

  always @(negedge clk) if (m_init) begin
    chk("m_addr", imem_addr, m_pc);
    chk("m_rd_en", 32'(imem_rd_en), 32'(!m_halt));
    chk("m_halted", 32'(halted), 32'(m_halt));
    chk("m_err", 32'(fetch_err), 32'(m_err));
    chk("m_valid", 32'(ifid_valid), 32'(m_v));
    chk("m_instr", ifid_instr, m_ins);
    chk("m_pc", ifid_pc, m_ipc);
    chk("m_pc4", ifid_pc4, m_ipc4);
  end

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[0] = I0; mem[1] = I1; mem[2] = I2; mem[4] = HALT; mem[16] = W40; mem[255] = WEND;
    step(); step();
    rst = 1'b0;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("s1_addr4", imem_addr, 32'h4);
    chk("s1_instr", ifid_instr, I0);
    chk("s1_pc4", ifid_pc4, 32'h4);
    chk("s1_valid", 32'(ifid_valid), 32'h1);
    step();
    chk("s1_addr8", imem_addr, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("s2_addr", imem_addr, 32'h8);
      chk("s2_instr", ifid_instr, I1);
      chk("s2_pc", ifid_pc, 32'h4);
      chk("s2_pc4", ifid_pc4, 32'h8);
    end
    stall = 1'b0;
    step();
    chk("s2_rel_instr", ifid_instr, I2);
    chk("s2_rel_pc", ifid_pc, 32'h8);
    chk("s2_rel_addr", imem_addr, 32'hC);
    redirect = 1'b1; redirect_pc = 32'h43; stall = 1'b1;
    step();
    chk("s3_addr", imem_addr, 32'h40);
    chk("s3_valid", 32'(ifid_valid), 32'h0);
    redirect = 1'b0; stall = 1'b0;
    step();
    chk("s3_instr", ifid_instr, W40);
    chk("s3_pc", ifid_pc, 32'h40);
    redirect = 1'b1; redirect_pc = 32'd16;
    step();
    redirect = 1'b0;
    step();
    chk("s4_halted", 32'(halted), 32'h1);
    chk("s4_addr", imem_addr, 32'd16);
    chk("s4_rd_en", 32'(imem_rd_en), 32'h0);
    chk("s4_valid", 32'(ifid_valid), 32'h0);
    step();
    chk("s4_hold", imem_addr, 32'd16);
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    chk("s4_exit", 32'(halted), 32'h0);
    redirect = 1'b0;
    step();
    chk("s4_i0", ifid_instr, I0);
    redirect = 1'b1; redirect_pc = 32'd1020;
    step();
    chk("s5_addr", imem_addr, 32'd1020);
    redirect = 1'b0;
    step();
    chk("s5_instr", ifid_instr, WEND);
    chk("s5_pc", ifid_pc, 32'd1020);
    chk("s5_addr1024", imem_addr, 32'd1024);
    chk("s5_noerr", 32'(fetch_err), 32'h0);
    step();
    chk("s5_err", 32'(fetch_err), 32'h1);
    chk("s5_halted", 32'(halted), 32'h1);
    chk("s5_valid", 32'(ifid_valid), 32'h0);
    redirect = 1'b1; redirect_pc = 32'h0;
    step();
    chk("s5_sticky", 32'(fetch_err), 32'h1);
    redirect = 1'b0;
    step(); step();
    stall = 1'b1;
    step();
    chk("s6_valid", 32'(ifid_valid), 32'h1);
    rst = 1'b1;
    step();
    chk("s6_addr", imem_addr, 32'h0);
    chk("s6_valid0", 32'(ifid_valid), 32'h0);
    chk("s6_err0", 32'(fetch_err), 32'h0);
    chk("s6_run", 32'(halted), 32'h0);
    stall = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      step();
      rst = $urandom_range(0, 99) == 0;
      redirect = $urandom_range(0, 9) == 0;
      redirect_pc = $urandom_range(0, 1100);
      flush = $urandom_range(0, 7) == 0;
      stall = $urandom_range(0, 4) == 0;
    end
    rst = 1'b0; redirect = 1'b0; flush = 1'b0; stall = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
